// File: rtl/lsb_dcache.sv
// rtl/lsb_dcache.sv - direct-mapped write-back data cache with uncached MMIO byte path; DCACHE_PERF_EN adds hit/miss counters
module lsb_dcache #(
   parameter int          SETS       = 16,
   parameter int          LINE_BYTES = 16,
   parameter int          TAG_W      = 4,
   parameter logic [31:0] IO_BASE    = 32'h30000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [1:0]              req_size,
   input  logic                    req_signed,
   input  logic [31:0]             req_addr,
   input  logic [31:0]             req_wdata,
   input  logic [TAG_W-1:0]        req_tag,
   output logic                    resp_valid,
   output logic [TAG_W-1:0]        resp_tag,
   output logic [31:0]             resp_rdata,
   output logic                    mem_valid,
   output logic                    mem_we,
   output logic [31:0]             mem_addr,
   output logic [8*LINE_BYTES-1:0] mem_wline,
   input  logic                    mem_ready,
   input  logic [8*LINE_BYTES-1:0] mem_rline,
   output logic                    io_valid,
   output logic                    io_we,
   output logic [31:0]             io_addr,
   output logic [7:0]              io_wbyte,
   input  logic                    io_ready,
   input  logic [7:0]              io_rbyte
`ifdef DCACHE_PERF_EN
   ,
   output logic [31:0]             perf_hits,
   output logic [31:0]             perf_misses
`endif
);
   localparam int IDX_W  = $clog2(SETS);
   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int LINE_W = 8 * LINE_BYTES;
   localparam int ATAG_W = 32 - OFF_W - IDX_W;

   typedef enum logic [1:0] {S_IDLE, S_EVICT, S_FILL, S_IO} state_t;
   state_t state;

   logic [LINE_W-1:0] line_data  [SETS];
   logic [ATAG_W-1:0] line_tag   [SETS];
   logic [SETS-1:0]   line_valid;
   logic [SETS-1:0]   line_dirty;

   // request fields held for the duration of a miss or IO access
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_signed;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [TAG_W-1:0]  r_tag;

   logic [OFF_W-1:0]  req_off, r_off;
   logic [IDX_W-1:0]  req_idx, r_idx;
   logic [ATAG_W-1:0] req_atag, r_atag;
   logic              req_io;
   logic              req_hit;

   assign req_off  = req_addr[OFF_W-1:0];
   assign req_idx  = req_addr[OFF_W +: IDX_W];
   assign req_atag = req_addr[31 -: ATAG_W];
   assign r_off    = r_addr[OFF_W-1:0];
   assign r_idx    = r_addr[OFF_W +: IDX_W];
   assign r_atag   = r_addr[31 -: ATAG_W];
   assign req_io   = (req_addr >= IO_BASE);
   assign req_hit  = line_valid[req_idx] && (line_tag[req_idx] == req_atag);

   // zero/sign extension of the low byte, half or full word
   function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] size,
                                          input logic sgn);
      case (size)
         2'd0:    extend = {{24{sgn & w[7]}}, w[7:0]};
         2'd1:    extend = {{16{sgn & w[15]}}, w[15:0]};
         default: extend = w;
      endcase
   endfunction

   // little-endian extraction of a load from a line
   function automatic logic [31:0] load_line(input logic [LINE_W-1:0] line,
                                             input logic [OFF_W-1:0] off,
                                             input logic [1:0] size, input logic sgn);
      logic [LINE_W-1:0] sh;
      sh = line >> {off, 3'b000};
      return extend(sh[31:0], size, sgn);
   endfunction

   // byte-lane merge of store data into a line
   function automatic logic [LINE_W-1:0] store_line(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0] off,
                                                    input logic [1:0] size,
                                                    input logic [31:0] wdata);
      logic [31:0]       m32;
      logic [LINE_W-1:0] mask;
      logic [LINE_W-1:0] data;
      case (size)
         2'd0:    m32 = 32'h0000_00FF;
         2'd1:    m32 = 32'h0000_FFFF;
         default: m32 = 32'hFFFF_FFFF;
      endcase
      mask = LINE_W'(m32) << {off, 3'b000};
      data = LINE_W'(wdata & m32) << {off, 3'b000};
      return (line & ~mask) | data;
   endfunction

   // controller: hit service, victim write-back, line fill, MMIO byte access
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_tag    <= '0;
         resp_rdata  <= '0;
         mem_valid   <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wline   <= '0;
         io_valid    <= 1'b0;
         io_we       <= 1'b0;
         io_addr     <= '0;
         io_wbyte    <= '0;
         line_valid  <= '0;
         line_dirty  <= '0;
`ifdef DCACHE_PERF_EN
         perf_hits   <= '0;
         perf_misses <= '0;
`endif
      end else begin
         resp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we     <= req_we;
                  r_size   <= req_size;
                  r_signed <= req_signed;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
                  r_tag    <= req_tag;
                  if (req_io) begin
                     state     <= S_IO;
                     req_ready <= 1'b0;
                     io_valid  <= 1'b1;
                     io_we     <= req_we;
                     io_addr   <= req_addr;
                     io_wbyte  <= req_wdata[7:0];
                  end else if (req_hit) begin
                     resp_valid <= 1'b1;
                     resp_tag   <= req_tag;
                     if (req_we) begin
                        line_data[req_idx]  <= store_line(line_data[req_idx], req_off,
                                                          req_size, req_wdata);
                        line_dirty[req_idx] <= 1'b1;
                        resp_rdata          <= '0;
                     end else begin
                        resp_rdata <= load_line(line_data[req_idx], req_off, req_size,
                                                req_signed);
                     end
`ifdef DCACHE_PERF_EN
                     perf_hits <= perf_hits + 32'd1;
`endif
                  end else begin
                     req_ready <= 1'b0;
                     mem_valid <= 1'b1;
                     if (line_valid[req_idx] && line_dirty[req_idx]) begin
                        state     <= S_EVICT;
                        mem_we    <= 1'b1;
                        mem_addr  <= {line_tag[req_idx], req_idx, {OFF_W{1'b0}}};
                        mem_wline <= line_data[req_idx];
                     end else begin
                        state    <= S_FILL;
                        mem_we   <= 1'b0;
                        mem_addr <= {req_atag, req_idx, {OFF_W{1'b0}}};
                     end
`ifdef DCACHE_PERF_EN
                     perf_misses <= perf_misses + 32'd1;
`endif
                  end
               end
            end
            S_EVICT: begin
               if (mem_ready) begin
                  line_dirty[r_idx] <= 1'b0;
                  mem_valid         <= 1'b0;
                  state             <= S_FILL;
               end
            end
            S_FILL: begin
               // after an eviction mem_valid is low for one cycle before the fill is issued
               if (!mem_valid) begin
                  mem_valid <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= {r_atag, r_idx, {OFF_W{1'b0}}};
               end else if (mem_ready) begin
                  mem_valid         <= 1'b0;
                  line_tag[r_idx]   <= r_atag;
                  line_valid[r_idx] <= 1'b1;
                  if (r_we) begin
                     line_data[r_idx]  <= store_line(mem_rline, r_off, r_size, r_wdata);
                     line_dirty[r_idx] <= 1'b1;
                     resp_rdata        <= '0;
                  end else begin
                     line_data[r_idx]  <= mem_rline;
                     line_dirty[r_idx] <= 1'b0;
                     resp_rdata        <= load_line(mem_rline, r_off, r_size, r_signed);
                  end
                  resp_valid <= 1'b1;
                  resp_tag   <= r_tag;
                  req_ready  <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            S_IO: begin
               if (io_ready) begin
                  io_valid   <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_tag   <= r_tag;
                  resp_rdata <= r_we ? 32'd0 : extend({24'd0, io_rbyte}, 2'd0, r_signed);
                  req_ready  <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
               mem_valid <= 1'b0;
               io_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsb_dcache.sv
// tb/tb_lsb_dcache.sv - directed scoreboard bench for lsb_dcache
module tb_lsb_dcache;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_we = 1'b0;
   logic [1:0]   req_size = 2'd0;
   logic         req_signed = 1'b0;
   logic [31:0]  req_addr = '0;
   logic [31:0]  req_wdata = '0;
   logic [3:0]   req_tag = '0;
   logic         resp_valid;
   logic [3:0]   resp_tag;
   logic [31:0]  resp_rdata;
   logic         mem_valid;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wline;
   logic         mem_ready = 1'b0;
   logic [127:0] mem_rline = '0;
   logic         io_valid;
   logic         io_we;
   logic [31:0]  io_addr;
   logic [7:0]   io_wbyte;
   logic         io_ready = 1'b0;
   logic [7:0]   io_rbyte = '0;
`ifdef DCACHE_PERF_EN
   logic [31:0]  perf_hits;
   logic [31:0]  perf_misses;
`endif

   int total = 0;
   int bad = 0;
   logic [35:0] sb_q[$];

   lsb_dcache dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_rdata(resp_rdata),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wline(mem_wline),
      .mem_ready(mem_ready), .mem_rline(mem_rline),
      .io_valid(io_valid), .io_we(io_we), .io_addr(io_addr), .io_wbyte(io_wbyte),
      .io_ready(io_ready), .io_rbyte(io_rbyte)
`ifdef DCACHE_PERF_EN
      , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // scoreboard: every response must match the oldest expected entry
   always @(negedge clk) begin
      if (!rst && resp_valid) begin
         if (sb_q.size() == 0) begin
            chk("resp_unexpected", resp_valid, 1'b0);
         end else begin
            logic [35:0] e;
            e = sb_q.pop_front();
            chk("resp_tag", resp_tag, e[35:32]);
            chk("resp_rdata", resp_rdata, e[31:0]);
         end
      end
   end

   task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] tg,
                        input logic [31:0] exp, input logic expect_resp);
      int n = 0;
      while (!req_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("req_ready_wait", req_ready, 1'b1);
      if (expect_resp) sb_q.push_back({tg, exp});
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd; req_tag = tg;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic serve_mem(input string nm, input logic exp_we, input logic [31:0] exp_addr,
                            input logic [127:0] rline);
      int n = 0;
      while (!mem_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_valid"}, mem_valid, 1'b1);
      chk({nm, "_we"}, mem_we, exp_we);
      chk({nm, "_addr"}, mem_addr, exp_addr);
      repeat (2) @(posedge clk);
      #1;
      chk({nm, "_addr_stable"}, mem_addr, exp_addr);
      mem_ready = 1'b1; mem_rline = rline;
      @(posedge clk); #1;
      mem_ready = 1'b0; mem_rline = '0;
      chk({nm, "_drop"}, mem_valid, 1'b0);
   endtask

   task automatic serve_io(input string nm, input logic exp_we, input logic [31:0] exp_addr,
                           input logic [7:0] rbyte);
      int n = 0;
      while (!io_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_valid"}, io_valid, 1'b1);
      chk({nm, "_we"}, io_we, exp_we);
      chk({nm, "_addr"}, io_addr, exp_addr);
      @(posedge clk); #1;
      io_ready = 1'b1; io_rbyte = rbyte;
      @(posedge clk); #1;
      io_ready = 1'b0; io_rbyte = '0;
      chk({nm, "_drop"}, io_valid, 1'b0);
      chk({nm, "_resp_now"}, resp_valid, 1'b1);
   endtask

   initial begin
      logic [127:0] line0, line1, line2, line3;
      line0 = '0; line0[31:0] = 32'hDEADBEEF;
      line1 = '0; line1[63:32] = 32'hCAFEF00D;
      line2 = '0; line2[31:0] = 32'h0BADF00D; line2[63:32] = 32'h01020304;
      line3 = '0; line3[31:0] = 32'h55AA55AA;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_valid", mem_valid, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_io_valid", io_valid, 1'b0);
      rst = 1'b0;

      // clean miss then hit
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 4'd1, 32'hDEADBEEF, 1'b1);
      chk("miss_mem_valid_t1", mem_valid, 1'b1);
      chk("miss_no_resp", resp_valid, 1'b0);
      serve_mem("fill0", 1'b0, 32'h100, line0);
      chk("fill0_resp_f1", resp_valid, 1'b1);
      chk("fill0_ready_f1", req_ready, 1'b1);
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 4'd2, 32'hDEADBEEF, 1'b1);
      chk("hit_resp_t1", resp_valid, 1'b1);
      chk("hit_no_mem", mem_valid, 1'b0);

      // back-to-back load extension hits
      issue(1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 4'd3, 32'hFFFFFFDE, 1'b1);
      issue(1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 4'd4, 32'h000000DE, 1'b1);
      issue(1'b0, 2'd1, 1'b1, 32'h102, 32'd0, 4'd5, 32'hFFFFDEAD, 1'b1);
      issue(1'b0, 2'd1, 1'b0, 32'h102, 32'd0, 4'd6, 32'h0000DEAD, 1'b1);
      chk("b2b_resp", resp_valid, 1'b1);

      // dirty eviction with gap before fill
      issue(1'b1, 2'd2, 1'b0, 32'h104, 32'h12345678, 4'd7, 32'd0, 1'b1);
      chk("sw_hit_resp", resp_valid, 1'b1);
      issue(1'b0, 2'd2, 1'b0, 32'h204, 32'd0, 4'd8, 32'hCAFEF00D, 1'b1);
      chk("evict_mem_valid_t1", mem_valid, 1'b1);
      chk("evict_wline_w1", mem_wline[63:32], 32'h12345678);
      chk("evict_wline_w0", mem_wline[31:0], 32'hDEADBEEF);
      serve_mem("evict", 1'b1, 32'h100, '0);
      @(posedge clk); #1;
      chk("gap_refill_valid", mem_valid, 1'b1);
      serve_mem("fill1", 1'b0, 32'h200, line1);
      chk("fill1_resp", resp_valid, 1'b1);

      // MMIO byte path
      issue(1'b1, 2'd0, 1'b0, 32'h30000, 32'h00000041, 4'd9, 32'd0, 1'b1);
      chk("io_wbyte", io_wbyte, 8'h41);
      chk("io_no_mem", mem_valid, 1'b0);
      serve_io("io_sb", 1'b1, 32'h30000, 8'h00);
      issue(1'b0, 2'd0, 1'b1, 32'h30004, 32'd0, 4'd10, 32'hFFFFFF80, 1'b1);
      serve_io("io_lb", 1'b0, 32'h30004, 8'h80);
      chk("io_lb_no_mem", mem_valid, 1'b0);

      // reset during fill drops the request
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 4'd11, 32'd0, 1'b0);
      chk("rf_mem_valid", mem_valid, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rf_mem_dropped", mem_valid, 1'b0);
      chk("rf_req_ready", req_ready, 1'b1);
      chk("rf_no_resp", resp_valid, 1'b0);
      @(posedge clk); #1;

      // refetch after reset, then 3 hits, another miss, one IO access
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 4'd12, 32'h0BADF00D, 1'b1);
      chk("rf_remiss", mem_valid, 1'b1);
      serve_mem("fill2", 1'b0, 32'h100, line2);
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 4'd13, 32'h0BADF00D, 1'b1);
      issue(1'b0, 2'd0, 1'b0, 32'h100, 32'd0, 4'd14, 32'h0000000D, 1'b1);
      issue(1'b0, 2'd2, 1'b0, 32'h104, 32'd0, 4'd15, 32'h01020304, 1'b1);
      issue(1'b0, 2'd2, 1'b0, 32'h300, 32'd0, 4'd0, 32'h55AA55AA, 1'b1);
      serve_mem("fill3", 1'b0, 32'h300, line3);
      issue(1'b0, 2'd0, 1'b1, 32'h30001, 32'd0, 4'd1, 32'h0000007F, 1'b1);
      serve_io("io_lb2", 1'b0, 32'h30001, 8'h7F);
`ifdef DCACHE_PERF_EN
      chk("perf_misses", perf_misses, 32'd2);
      chk("perf_hits", perf_hits, 32'd3);
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 128'(sb_q.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
